// File: rtl/seq_detect_controller.sv
// seq_detect_controller: runs a latched test word through an external 010110 sequence detector
//   Clears the detector, shifts the word MSB-first and counts hits with mode-correct latency.
//   i_clock     rising-edge clock
//   i_reset     asynchronous reset, active-low
//   i_start     1-cycle run request, honoured only in IDLE
//   i_abort     ends a run without a done pulse (wins over i_start in IDLE)
//   i_mode      0 = Moore, 1 = Mealy; latched on an accepted start
//   i_word      test word; latched on an accepted start
//   o_det_rst   synchronous clear to the detector (IDLE and CLR)
//   o_det_x     serial data to the detector
//   o_det_m     mode select to the detector
//   i_det_z     detector output
//   o_busy      high in every state except IDLE
//   o_done      1-cycle pulse with final results
//   o_hit_count hits in the last completed run
//   o_first_pos bit index of the first hit (0 when none)
//   o_no_hit    last completed run had no hits
module seq_detect_controller #(
    parameter int WIDTH = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic                         i_mode,
    input  logic [WIDTH-1:0]             i_word,
    output logic                         o_det_rst,
    output logic                         o_det_x,
    output logic                         o_det_m,
    input  logic                         i_det_z,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(WIDTH+1)-1:0]   o_hit_count,
    output logic [$clog2(WIDTH)-1:0]     o_first_pos,
    output logic                         o_no_hit
);
    localparam int CW = $clog2(WIDTH+1);
    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH-1);
    localparam logic [CW-1:0] C_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_shift;
    logic            r_mode;
    logic [KW-1:0]   r_k;
    logic [CW-1:0]   r_cnt;
    logic [KW-1:0]   r_first;
    logic [CW-1:0]   r_hit_count;
    logic [KW-1:0]   r_first_pos;
    logic            r_no_hit;
    logic            w_accept;
    logic            w_credit;
    logic [KW-1:0]   w_idx;
    logic [CW-1:0]   w_cnt_nxt;
    logic [KW-1:0]   w_first_nxt;

    assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;

    // Mealy output reflects the current bit; Moore output lags one cycle, so it
    // skips SHIFT 0 and is still collected in DRAIN for the last bit.
    assign w_credit = i_det_z && (((r_state == S_SHIFT) && (r_mode || r_k != '0)) ||
                                  ((r_state == S_DRAIN) && !r_mode));
    assign w_idx = (r_state == S_DRAIN) ? K_LAST : r_k - KW'(!r_mode);
    assign w_cnt_nxt = r_cnt + CW'(w_credit && (r_cnt != C_MAX));
    assign w_first_nxt = (w_credit && r_cnt == '0) ? w_idx : r_first;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_CLR : S_IDLE;
            S_CLR:   w_next = S_SHIFT;
            S_SHIFT: w_next = (r_k == K_LAST) ? S_DRAIN : S_SHIFT;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    always_comb begin
        o_busy    = r_state != S_IDLE;
        o_done    = r_state == S_DONE;
        o_det_rst = (r_state == S_IDLE) || (r_state == S_CLR);
        o_det_x   = (r_state == S_SHIFT) && r_shift[WIDTH-1];
        o_det_m   = (r_state != S_IDLE) && r_mode;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_shift     <= '0;
            r_mode      <= 1'b0;
            r_k         <= '0;
            r_cnt       <= '0;
            r_first     <= '0;
            r_hit_count <= '0;
            r_first_pos <= '0;
            r_no_hit    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_shift <= i_word;
                r_mode  <= i_mode;
            end else if (r_state == S_SHIFT) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end
            if (r_state == S_CLR) begin
                r_k     <= '0;
                r_cnt   <= '0;
                r_first <= '0;
            end else begin
                if (r_state == S_SHIFT && r_k != K_LAST) r_k <= r_k + 1'b1;
                r_cnt   <= w_cnt_nxt;
                r_first <= w_first_nxt;
            end
            // Results are loaded on entry to DONE so they are valid alongside the done pulse.
            if (r_state == S_DRAIN && !i_abort) begin
                r_hit_count <= w_cnt_nxt;
                r_no_hit    <= w_cnt_nxt == '0;
                r_first_pos <= (w_cnt_nxt == '0) ? '0 : w_first_nxt;
            end
        end
    end

    assign o_hit_count = r_hit_count;
    assign o_first_pos = r_first_pos;
    assign o_no_hit    = r_no_hit;
endmodule

// File: tb/tb_seq_detect_controller.sv
// tb_seq_detect_controller: directed bench with a behavioural 010110 detector and a result scoreboard
module tb_seq_detect_controller;
    localparam int W = 16;

    typedef struct {
        int cnt;
        int first;
        int done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] word = '0;
    logic        det_rst, det_x, det_m, det_z;
    logic        busy, done, no_hit;
    logic [4:0]  hit_count;
    logic [3:0]  first_pos;
    logic [5:0]  hist;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];

    seq_detect_controller #(.WIDTH(W)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
        .i_mode(mode), .i_word(word), .o_det_rst(det_rst), .o_det_x(det_x),
        .o_det_m(det_m), .i_det_z(det_z), .o_busy(busy), .o_done(done),
        .o_hit_count(hit_count), .o_first_pos(first_pos), .o_no_hit(no_hit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Overlapping 010110 detector; all-ones history after clear keeps partial windows from matching.
    always @(posedge clk) hist <= det_rst ? 6'h3F : {hist[4:0], det_x};
    assign det_z = det_m ? (hist[4:0] == 5'b01011 && !det_x) : (hist == 6'b010110);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t ref_run(input logic [15:0] w, input int done_cyc);
        exp_t e;
        logic [15:0] s;
        e.cnt = 0;
        e.first = 0;
        e.done_cyc = done_cyc;
        for (int i = 5; i < W; i++) begin
            s = w >> (15 - i);
            if (s[5:0] == 6'b010110) begin
                if (e.cnt == 0) e.first = i;
                e.cnt++;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            chk("done_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("hit_count", 32'(hit_count), e.cnt);
                chk("first_pos", 32'(first_pos), e.first);
                chk("no_hit", 32'(no_hit), 32'(e.cnt == 0));
            end
        end
    end

    // Leaves the bench at the negedge where the run is in CLR; word/mode are then scrambled.
    task automatic pulse_start(input logic [15:0] w, input logic m, input bit expect_done);
        @(negedge clk);
        word = w;
        mode = m;
        start = 1'b1;
        if (expect_done) q.push_back(ref_run(w, cyc + W + 3));
        @(negedge clk);
        start = 1'b0;
        word = 16'($urandom);
        mode = ~m;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && (q.size() != 0 || busy); i++) @(negedge clk);
        #1;
        chk(tag, 32'(q.size()), 0);
    endtask

    task automatic run(input logic [15:0] w, input logic m, input string tag);
        pulse_start(w, m, 1'b1);
        wait_idle(tag);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_det_rst", 32'(det_rst), 1);
        chk("rst_det_x", 32'(det_x), 0);
        chk("rst_det_m", 32'(det_m), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_hit", 32'(hit_count), 0);
        chk("rst_first", 32'(first_pos), 0);
        chk("rst_no_hit", 32'(no_hit), 1);
        rst_n = 1'b1;

        run(16'h0016, 1'b0, "t1_moore");
        pulse_start(16'h0016, 1'b1, 1'b1);
        chk("clr_det_rst", 32'(det_rst), 1);
        chk("clr_det_m", 32'(det_m), 1);
        for (int k = 0; k < W; k++) begin
            logic [15:0] v = 16'h0016;
            @(negedge clk);
            chk("shift_det_x", 32'(det_x), 32'(v[15-k]));
            chk("shift_det_rst", 32'(det_rst), 0);
        end
        wait_idle("t2_mealy");

        run(16'h02D6, 1'b0, "t3_moore");
        run(16'h02D6, 1'b1, "t3_mealy");
        run(16'h0000, 1'b0, "t4_zero_moore");
        run(16'h0000, 1'b1, "t4_zero_mealy");
        run(16'hFFFF, 1'b0, "t4_ones_moore");
        run(16'hFFFF, 1'b1, "t4_ones_mealy");

        run(16'h02D6, 1'b0, "t5_prior");
        pulse_start(16'h0016, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_det_rst", 32'(det_rst), 1);
        repeat (W + 5) @(negedge clk);
        chk("abort_hit", 32'(hit_count), 2);
        chk("abort_first", 32'(first_pos), 10);
        chk("abort_no_hit", 32'(no_hit), 0);

        start = 1'b1;
        abort = 1'b1;
        word = 16'h0016;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", 32'(busy), 0);

        pulse_start(16'h02D6, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        word = 16'h0016;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t6_start_in_shift");

        pulse_start(16'h0016, 1'b0, 1'b1);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk("done_seen", 32'(done), 1);
        start = 1'b1;
        word = 16'h02D6;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_busy", 32'(busy), 0);
        repeat (W + 5) @(negedge clk);
        chk("start_in_done_idle", 32'(busy), 0);
        chk("start_in_done_hit", 32'(hit_count), 1);

        pulse_start(16'h02D6, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_det_rst", 32'(det_rst), 1);
        chk("midrst_hit", 32'(hit_count), 0);
        chk("midrst_no_hit", 32'(no_hit), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run(16'h02D6, 1'b1, "t6_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
